// File: rtl/square_step_sched_if.sv
// Handshake bundle between the frame/control side and the step scheduler.
// The master side drives the control pulses and mask; the scheduler drives the strobes and status.
interface square_step_sched_if #(
  parameter int N_SQ = 3
);
  logic            frame_start;
  logic            run_toggle;
  logic            step_req;
  logic            speed_up;
  logic            speed_down;
  logic [N_SQ-1:0] square_en;
  logic [N_SQ-1:0] step_en;
  logic            busy;
  logic            running;
  logic [2:0]      speed;
  logic            overrun;
  logic [15:0]     frame_cnt;

  modport master (
    output frame_start, run_toggle, step_req, speed_up, speed_down, square_en,
    input  step_en, busy, running, speed, overrun, frame_cnt
  );

  modport slave (
    input  frame_start, run_toggle, step_req, speed_up, speed_down, square_en,
    output step_en, busy, running, speed, overrun, frame_cnt
  );
endinterface

// File: rtl/square_step_sched.sv
// Turns each vertical-blank pulse into a burst of gapped animate strobes for the square movers,
// with run/pause, single-step, speed control and sticky frame-overrun detection.
module square_step_sched #(
  parameter int N_SQ         = 3,
  parameter int MAX_SPEED    = 4,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input logic               clk,
  input logic               rst,
  square_step_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      budget_reg, budget_next;
  logic            running_reg, running_next;
  logic            pending_reg, pending_next;
  logic [2:0]      speed_reg, speed_next;
  logic            overrun_reg, overrun_next;
  logic [15:0]     frame_cnt_reg, frame_cnt_next;
  logic [N_SQ-1:0] step_en_reg, step_en_next;
  logic            busy_reg, busy_next;
  logic            issue_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      budget_reg    <= '0;
      running_reg   <= RUN_AT_RESET;
      pending_reg   <= 1'b0;
      speed_reg     <= 3'd1;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= '0;
      step_en_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      budget_reg    <= budget_next;
      running_reg   <= running_next;
      pending_reg   <= pending_next;
      speed_reg     <= speed_next;
      overrun_reg   <= overrun_next;
      frame_cnt_reg <= frame_cnt_next;
      step_en_reg   <= step_en_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    budget_next    = budget_reg;
    running_next   = running_reg;
    pending_next   = pending_reg;
    speed_next     = speed_reg;
    overrun_next   = overrun_reg;
    frame_cnt_next = frame_cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.frame_start) begin
          frame_cnt_next = frame_cnt_reg + 16'd1;
          // Decision uses the pre-toggle running value sampled this cycle.
          if (running_reg) begin
            budget_next = speed_reg;
            state_next  = ISSUE;
          end else if (pending_reg) begin
            budget_next  = 3'd1;
            pending_next = 1'b0;
            state_next   = ISSUE;
          end
        end
      end
      ISSUE: begin
        budget_next = budget_reg - 3'd1;
        state_next  = GAP;
      end
      GAP: begin
        state_next = (budget_reg == 3'd0) ? IDLE : ISSUE;
      end
      default: state_next = IDLE;
    endcase

    if (bus.frame_start && (state_reg != IDLE))
      overrun_next = 1'b1;

    if (bus.step_req && !running_reg)
      pending_next = 1'b1;

    // Resuming discards any step still waiting for a frame.
    if (bus.run_toggle) begin
      running_next = !running_reg;
      if (!running_reg)
        pending_next = 1'b0;
    end

    if (bus.speed_up && !bus.speed_down && (speed_reg < 3'(MAX_SPEED)))
      speed_next = speed_reg + 3'd1;
    else if (bus.speed_down && !bus.speed_up && (speed_reg > 3'd1))
      speed_next = speed_reg - 3'd1;
  end

  assign issue_next = (state_next == ISSUE);
  assign busy_next  = (state_next != IDLE);

  // The mask is captured on the same edge that enters ISSUE, so each strobe sees a fresh mask.
  generate
    for (genvar gi = 0; gi < N_SQ; gi++) begin : g_strobe
      assign step_en_next[gi] = issue_next & bus.square_en[gi];
    end
  endgenerate

  assign bus.step_en   = step_en_reg;
  assign bus.busy      = busy_reg;
  assign bus.running   = running_reg;
  assign bus.speed     = speed_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_square_step_sched.sv
// Directed bench for the square step scheduler: burst timing, speed, pause/step,
// overrun, mask changes, reset mid-burst and frame counter wrap.
module tb_square_step_sched;
  localparam int N_SQ = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  square_step_sched_if #(.N_SQ(N_SQ)) bus ();

  square_step_sched #(
    .N_SQ(N_SQ), .MAX_SPEED(4), .RUN_AT_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame at cycle t and samples cycles t+1..t+ncyc; bit i of the maps is cycle t+1+i.
  // A second frame_start is driven during cycle t+inject_at when inject_at is non-zero.
  task automatic run_frame(input int inject_at, input int ncyc, input logic toggle,
                           output logic [31:0] smap, output logic [31:0] bmap,
                           output logic [N_SQ-1:0] first_en);
    smap = '0;
    bmap = '0;
    first_en = '0;
    bus.frame_start = 1'b1;
    bus.run_toggle  = toggle;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      bus.run_toggle  = 1'b0;
      bus.frame_start = (inject_at != 0) && (i + 1 == inject_at);
      if (bus.step_en != '0) begin
        smap[i] = 1'b1;
        if (first_en == '0) first_en = bus.step_en;
      end
      if (bus.busy) bmap[i] = 1'b1;
    end
    bus.frame_start = 1'b0;
  endtask

  task automatic pulse_speed(input logic up, input logic down, input int n);
    for (int i = 0; i < n; i++) begin
      bus.speed_up   = up;
      bus.speed_down = down;
      tick();
    end
    bus.speed_up   = 1'b0;
    bus.speed_down = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.frame_start = 0; bus.run_toggle = 0; bus.step_req = 0;
    bus.speed_up = 0; bus.speed_down = 0; bus.square_en = 3'b111;
    tick(); tick();
    rst = 1'b0;
    exp_frames = 0;
    n_cmp++; if (bus.step_en !== 3'b000) begin n_bad++; $display("FAIL reset_step_en: got %b expected 000", bus.step_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    n_cmp++; if (bus.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    n_cmp++; if (bus.speed !== 3'd1) begin n_bad++; $display("FAIL reset_speed: got %0d expected 1", bus.speed); end
    n_cmp++; if (bus.running !== 1'b1) begin n_bad++; $display("FAIL reset_running: got %b expected 1", bus.running); end
    $display("test_reset done");
  endtask

  task automatic test_basic_burst();
    logic [31:0] smap, bmap;
    logic [N_SQ-1:0] first_en;
    bus.square_en = 3'b111;
    run_frame(0, 6, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h1) begin n_bad++; $display("FAIL basic_strobes: got %h expected 00000001", smap); end
    n_cmp++; if (first_en !== 3'b111) begin n_bad++; $display("FAIL basic_step_en: got %b expected 111", first_en); end
    n_cmp++; if (bmap !== 32'h3) begin n_bad++; $display("FAIL basic_busy: got %h expected 00000003", bmap); end
    n_cmp++; if (bus.frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL basic_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    $display("test_basic_burst strobes=%h busy=%h", smap, bmap);
  endtask

  task automatic test_speed();
    logic [31:0] smap, bmap;
    logic [N_SQ-1:0] first_en;
    pulse_speed(1'b1, 1'b0, 5);
    n_cmp++; if (bus.speed !== 3'd4) begin n_bad++; $display("FAIL speed_sat_max: got %0d expected 4", bus.speed); end
    pulse_speed(1'b1, 1'b1, 1);
    n_cmp++; if (bus.speed !== 3'd4) begin n_bad++; $display("FAIL speed_both: got %0d expected 4", bus.speed); end
    pulse_speed(1'b0, 1'b1, 5);
    n_cmp++; if (bus.speed !== 3'd1) begin n_bad++; $display("FAIL speed_sat_min: got %0d expected 1", bus.speed); end
    pulse_speed(1'b1, 1'b0, 3);
    n_cmp++; if (bus.speed !== 3'd4) begin n_bad++; $display("FAIL speed_back_up: got %0d expected 4", bus.speed); end
    run_frame(0, 12, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h55) begin n_bad++; $display("FAIL speed_strobes: got %h expected 00000055", smap); end
    n_cmp++; if (bmap !== 32'hFF) begin n_bad++; $display("FAIL speed_busy: got %h expected 000000ff", bmap); end
    $display("test_speed strobes=%h busy=%h", smap, bmap);
  endtask

  task automatic test_pause_step();
    logic [31:0] smap, bmap;
    logic [N_SQ-1:0] first_en;
    // Toggle in the same cycle as frame_start: burst still runs at full speed.
    run_frame(0, 12, 1'b1, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h55) begin n_bad++; $display("FAIL toggle_frame_strobes: got %h expected 00000055", smap); end
    n_cmp++; if (bus.running !== 1'b0) begin n_bad++; $display("FAIL paused: got %b expected 0", bus.running); end
    bus.step_req = 1'b1; tick(); bus.step_req = 1'b0; tick();
    bus.step_req = 1'b1; tick(); bus.step_req = 1'b0; tick();
    run_frame(0, 8, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h1) begin n_bad++; $display("FAIL single_step_strobes: got %h expected 00000001", smap); end
    n_cmp++; if (bmap !== 32'h3) begin n_bad++; $display("FAIL single_step_busy: got %h expected 00000003", bmap); end
    run_frame(0, 8, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h0) begin n_bad++; $display("FAIL step_consumed: got %h expected 00000000", smap); end
    bus.run_toggle = 1'b1; tick(); bus.run_toggle = 1'b0;
    n_cmp++; if (bus.running !== 1'b1) begin n_bad++; $display("FAIL resumed: got %b expected 1", bus.running); end
    bus.step_req = 1'b1; tick(); bus.step_req = 1'b0; tick();
    run_frame(0, 12, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (smap !== 32'h55) begin n_bad++; $display("FAIL step_while_running: got %h expected 00000055", smap); end
    n_cmp++; if (bus.frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL pause_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    $display("test_pause_step frames=%0d", bus.frame_cnt);
  endtask

  task automatic test_back_to_back();
    logic [31:0] smap, bmap;
    logic [N_SQ-1:0] first_en;
    // Second frame exactly at t+2k+1 is accepted without overrun.
    run_frame(9, 20, 1'b0, smap, bmap, first_en);
    exp_frames += 2;
    n_cmp++; if (smap !== 32'hAA55) begin n_bad++; $display("FAIL b2b_strobes: got %h expected 0000aa55", smap); end
    n_cmp++; if (bmap !== 32'h1FEFF) begin n_bad++; $display("FAIL b2b_busy: got %h expected 0001feff", bmap); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b expected 0", bus.overrun); end
    n_cmp++; if (bus.frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL b2b_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    $display("test_back_to_back strobes=%h busy=%h", smap, bmap);
  endtask

  task automatic test_overrun();
    logic [31:0] smap, bmap;
    logic [N_SQ-1:0] first_en;
    run_frame(4, 12, 1'b0, smap, bmap, first_en);
    exp_frames++;
    n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
    n_cmp++; if (bus.frame_cnt !== 16'(exp_frames)) begin n_bad++; $display("FAIL overrun_frame_cnt: got %0d expected %0d", bus.frame_cnt, exp_frames); end
    n_cmp++; if (smap !== 32'h55) begin n_bad++; $display("FAIL overrun_strobes: got %h expected 00000055", smap); end
    n_cmp++; if (bmap !== 32'hFF) begin n_bad++; $display("FAIL overrun_busy: got %h expected 000000ff", bmap); end
    $display("test_overrun overrun=%b frames=%0d", bus.overrun, bus.frame_cnt);
  endtask

  task automatic test_mask();
    bus.square_en = 3'b111;
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    n_cmp++; if (bus.step_en !== 3'b111) begin n_bad++; $display("FAIL mask_first: got %b expected 111", bus.step_en); end
    bus.square_en = 3'b010;
    tick();
    n_cmp++; if (bus.step_en !== 3'b000) begin n_bad++; $display("FAIL mask_gap: got %b expected 000", bus.step_en); end
    tick();
    n_cmp++; if (bus.step_en !== 3'b010) begin n_bad++; $display("FAIL mask_second: got %b expected 010", bus.step_en); end
    tick(); tick();
    n_cmp++; if (bus.step_en !== 3'b010) begin n_bad++; $display("FAIL mask_third: got %b expected 010", bus.step_en); end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mask_idle: got %b expected 0", bus.busy); end
    $display("test_mask done");
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] smap;
    bus.square_en = 3'b111;
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bus.step_en !== 3'b000) begin n_bad++; $display("FAIL rst_step_en: got %b expected 000", bus.step_en); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.speed !== 3'd1) begin n_bad++; $display("FAIL rst_speed: got %0d expected 1", bus.speed); end
    n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b expected 0", bus.overrun); end
    n_cmp++; if (bus.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_frame_cnt: got %0d expected 0", bus.frame_cnt); end
    smap = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.step_en != '0 || bus.busy) smap[i] = 1'b1;
    end
    n_cmp++; if (smap !== 32'h0) begin n_bad++; $display("FAIL rst_no_more_strobes: got %h expected 00000000", smap); end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_wrap();
    bus.run_toggle = 1'b1; tick(); bus.run_toggle = 1'b0;
    // Paused with no pending step: every frame_start is accepted while the FSM stays idle.
    bus.frame_start = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    bus.frame_start = 1'b0;
    n_cmp++; if (bus.frame_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %0d expected 65535", bus.frame_cnt); end
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
    n_cmp++; if (bus.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d expected 0", bus.frame_cnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wrap_busy: got %b expected 0", bus.busy); end
    $display("test_wrap frame_cnt=%0d", bus.frame_cnt);
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_speed();
    test_pause_step();
    test_back_to_back();
    test_overrun();
    test_mask();
    test_reset_mid_burst();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/square_step_sched.md
# square_step_sched

Step scheduler for the bouncing-square movers. It turns the once-per-frame vertical-blank pulse into bursts of one-cycle `animate` strobes, one strobe vector per step, fanned out to up to `N_SQ` square instances. It sits between the VGA timing generator and the square movers. It owns run/pause, single-step, the speed setting and frame-overrun detection.

## Interface
- `N_SQ`, 3, number of square movers driven (1..8).
- `MAX_SPEED`, 4, maximum steps issued per frame (1..7).
- `RUN_AT_RESET`, 1, value of `running` after reset.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `frame_start` input 1: one-cycle pulse at the start of vertical blank.
- `run_toggle` input 1: one-cycle pulse that toggles run/pause.
- `step_req` input 1: one-cycle pulse that requests a single step while paused.
- `speed_up` input 1: one-cycle pulse that increments speed.
- `speed_down` input 1: one-cycle pulse that decrements speed.
- `square_en` input N_SQ: per-square enable mask, sampled on every strobe cycle.
- `step_en` output N_SQ: per-square animate strobe, wired to each mover's `animate` input.
- `busy` output 1: high while a burst is in progress.
- `running` output 1: 1 means run, 0 means paused.
- `speed` output 3: current steps-per-frame, 1..MAX_SPEED.
- `overrun` output 1: sticky; set when `frame_start` arrives while `busy`.
- `frame_cnt` output 16: count of accepted `frame_start` pulses, wraps at 2^16.

## Operation
- FSM states are IDLE, ISSUE and GAP. Reset state is IDLE.
- **IDLE**
  - On `frame_start`, increment `frame_cnt`.
  - If `running`, load budget = `speed` and go to ISSUE.
  - Else if a single step is pending, load budget = 1, clear the pending flag and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drive `step_en = square_en` for exactly one cycle.
  - Decrement budget and go to GAP.
- **GAP**
  - `step_en = 0` for one cycle.
  - If budget is 0, go to IDLE; else go to ISSUE.
  - The gap guarantees the movers see strobes on non-adjacent cycles.
- **Frame overrun**
  - `frame_start` while in ISSUE or GAP sets `overrun`.
  - That pulse is not counted in `frame_cnt` and does not start a burst.
  - `overrun` is cleared only by `rst`.
- **Run/pause**
  - `run_toggle` flips `running` on the next cycle.
  - A burst already in progress always completes; it is never truncated.
- **Single step**
  - `step_req` while `running` = 0 sets the pending flag. Multiple requests before a frame collapse into one step.
  - `step_req` while `running` = 1 is ignored.
  - The pending flag clears when `running` goes to 1.
- **Speed**
  - `speed_up` increments `speed`, saturating at MAX_SPEED; `speed_down` decrements it, saturating at 1.
  - Both asserted in the same cycle: no change.
  - A speed change applies from the next burst; the current budget is unaffected.
- `square_en` bits may change mid-burst. Each strobe uses the mask present on its own ISSUE cycle.
- Reset mid-burst: on the next edge the FSM returns to IDLE and `step_en` is 0. No further strobes from the aborted burst.

## Timing
- Reset values:
  - `step_en` = 0, `busy` = 0, `overrun` = 0, `frame_cnt` = 0.
  - `speed` = 1, `running` = RUN_AT_RESET.
  - Pending flag clear, budget 0.
- All outputs are registered.
- With `frame_start` high at cycle t, budget k:
  - strobes on cycles t+1, t+3, …, t+2k−1;
  - `busy` high from t+1 through t+2k inclusive;
  - IDLE again at t+2k+1.
- A `frame_start` at t+2k+1 or later starts a new burst. One at cycles t+1..t+2k sets `overrun`.
- `frame_cnt` updates at t+1.
- `running`, `speed` and the pending flag update one cycle after their input pulse.
- A toggle and `frame_start` in the same cycle: the burst decision uses the pre-toggle `running`.

## Test plan
- **Reset and basic burst.** After reset, `speed` = 1, `running` = 1. Pulse `frame_start` at t with `square_en` = 3'b111 → `step_en` = 111 at t+1 only; `busy` high t+1..t+2; `frame_cnt` = 1.
- **Speed burst.** Pulse `speed_up` ×5 (MAX_SPEED = 4) → `speed` = 4. Next frame gives 4 strobes at t+1, t+3, t+5, t+7; `busy` falls at t+9. Then pulse `speed_up` and `speed_down` together → `speed` stays 4.
- **Pause and single step.**
  - Pause, then pulse `step_req` twice before a frame → exactly 1 strobe on the next frame and none on the following frame.
  - Pulse `step_req` while running → no extra strobe.
- **Overrun.** Speed 4, second `frame_start` at t+4 → `overrun` = 1 and `frame_cnt` unchanged by it. The burst finishes with 4 strobes.
- **Mask and reset.**
  - Change `square_en` from 111 to 010 between strobes → later strobes drive 010.
  - Assert `rst` at t+3 of a 4-step burst → `step_en` = 0 from t+4, `busy` = 0, `speed` = 1, `overrun` = 0.
- **Wrap.** Preload 65535 accepted frames (or force `frame_cnt`), then pulse `frame_start` → `frame_cnt` = 0.
